// File: rtl/ka_pkg.sv
// Shared types and helpers for the Karatsuba sequential carry-less multiplier.
// Holds the FSM state encoding and the low-half width function.
// Imported by the datapath top and by anything that needs the split width.
package ka_pkg;

   // Sequencer states: one compute state per Karatsuba partial product
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      M_LO  = 3'd1,
      M_HI  = 3'd2,
      M_MID = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Low-half width; the low half takes the extra bit when n is odd
   function automatic int ka_lo_w(input int n);
      return (n + 1) / 2;
   endfunction

endpackage

// File: rtl/ka_seq_mult_if.sv
// Operand/result handshake bundle for ka_seq_mult.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operand side and the result side.
interface ka_seq_mult_if #(
   parameter int N = 283
);
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   a;
   logic [N-1:0]   b;
   logic           out_valid;
   logic           out_ready;
   logic [2*N-2:0] y;
   logic           busy;

   // Producer of operands / consumer of products
   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, y, busy
   );

   // The multiplier itself
   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, y, busy
   );
endinterface

// File: rtl/ka_clmul_core.sv
// Combinational schoolbook carry-less (GF(2)[x]) multiplier, W x W -> 2W-1 bits.
// Latency: zero cycles (purely combinational).
// Backpressure: none; the caller decides when the result is sampled.
module ka_clmul_core #(
   parameter int W = 8
) (
   input  logic [W-1:0]   i_a,
   input  logic [W-1:0]   i_b,
   output logic [2*W-2:0] o_p
);

   // XOR-accumulate a shifted copy of b for every set bit of a
   always_comb begin
      o_p = '0;
      for (int i = 0; i < W; i++) begin
         if (i_a[i]) begin
            o_p = o_p ^ ((2*W-1)'(i_b) << i);
         end
      end
   end

endmodule

// File: rtl/ka_seq_mult.sv
// One-level Karatsuba carry-less multiplier sharing a single half-width core.
// Latency: out_valid rises 3 edges after the accepting edge; issue interval 5 cycles.
// Backpressure: in_ready only in IDLE; product held in DONE until out_ready.
module ka_seq_mult
   import ka_pkg::*;
#(
   parameter int N = 283
) (
   input  logic         clk,
   input  logic         rst_n,
   ka_seq_mult_if.slave s_bus
);

   localparam int L  = ka_lo_w(N);
   localparam int H  = N - L;
   localparam int PW = 2*L - 1;
   localparam int YW = 2*N - 1;

   state_t          r_state;
   logic [N-1:0]    r_a;
   logic [N-1:0]    r_b;
   logic [PW-1:0]   r_p0;
   logic [PW-1:0]   r_p2;
   logic [YW-1:0]   r_y;
   logic            r_out_vld;

   logic [L-1:0]    w_a_lo, w_a_hi, w_b_lo, w_b_hi;
   logic [L-1:0]    w_core_a, w_core_b;
   logic [PW-1:0]   w_core_p;
   logic [PW-1:0]   w_mid;
   logic [YW-1:0]   w_y_nxt;

   // High halves are H bits; zero-extend so the same L-bit core serves all three products
   assign w_a_lo = r_a[L-1:0];
   assign w_b_lo = r_b[L-1:0];
   assign w_a_hi = L'(r_a[N-1:N-H]);
   assign w_b_hi = L'(r_b[N-1:N-H]);

   // Steer the shared core: low halves by default, high halves, then the half sums
   always_comb begin
      w_core_a = w_a_lo;
      w_core_b = w_b_lo;
      case (r_state)
         M_HI: begin
            w_core_a = w_a_hi;
            w_core_b = w_b_hi;
         end
         M_MID: begin
            w_core_a = w_a_lo ^ w_a_hi;
            w_core_b = w_b_lo ^ w_b_hi;
         end
         default: ;
      endcase
   end

   ka_clmul_core #(.W(L)) u_core (
      .i_a (w_core_a),
      .i_b (w_core_b),
      .o_p (w_core_p)
   );

   // Middle term and final assembly; bits past 2N-2 are zero by construction
   assign w_mid   = w_core_p ^ r_p0 ^ r_p2;
   assign w_y_nxt = YW'(r_p0)
                  ^ YW'({w_mid, {L{1'b0}}})
                  ^ YW'({r_p2, {(2*L){1'b0}}});

   // Sequencer: accept, three core passes, then hold the product until taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_a       <= '0;
         r_b       <= '0;
         r_p0      <= '0;
         r_p2      <= '0;
         r_y       <= '0;
         r_out_vld <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (s_bus.in_valid) begin
                  r_a     <= s_bus.a;
                  r_b     <= s_bus.b;
                  r_state <= M_LO;
               end
            end
            M_LO: begin
               r_p0    <= w_core_p;
               r_state <= M_HI;
            end
            M_HI: begin
               r_p2    <= w_core_p;
               r_state <= M_MID;
            end
            M_MID: begin
               r_y       <= w_y_nxt;
               r_out_vld <= 1'b1;
               r_state   <= DONE;
            end
            DONE: begin
               if (s_bus.out_ready) begin
                  r_out_vld <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s_bus.in_ready  = (r_state == IDLE);
   assign s_bus.busy      = (r_state != IDLE);
   assign s_bus.out_valid = r_out_vld;
   assign s_bus.y         = r_y;

endmodule

// File: tb/tb_ka_seq_mult.sv
// Self-checking bench for ka_seq_mult at N=8, N=7 and N=283.
// Vector table plus hand sequences for latency, backpressure and mid-op reset.
// Products are checked by per-instance scoreboards on the result handshake.
module tb_ka_seq_mult;

   typedef struct {
      int           sel;
      logic [282:0] a;
      logic [282:0] b;
      logic [564:0] exp;
   } vec_t;

   logic clk;
   logic rst_n;

   int n_checks = 0;
   int n_err    = 0;

   logic [564:0] q8[$];
   logic [564:0] q7[$];
   logic [564:0] q283[$];

   ka_seq_mult_if #(.N(8))   if8();
   ka_seq_mult_if #(.N(7))   if7();
   ka_seq_mult_if #(.N(283)) if283();

   ka_seq_mult #(.N(8))   u_dut8   (.clk(clk), .rst_n(rst_n), .s_bus(if8));
   ka_seq_mult #(.N(7))   u_dut7   (.clk(clk), .rst_n(rst_n), .s_bus(if7));
   ka_seq_mult #(.N(283)) u_dut283 (.clk(clk), .rst_n(rst_n), .s_bus(if283));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [564:0] act, input logic [564:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      n_checks++;
      n_err++;
      $display("FAIL %s: timed out waiting on DUT", name);
   endtask

   // MSB-first shift-and-add over the bits of b
   function automatic logic [564:0] clmul_ref(input logic [282:0] a, input logic [282:0] b);
      logic [564:0] r;
      r = '0;
      for (int i = 282; i >= 0; i--) begin
         r = r << 1;
         if (b[i]) r = r ^ {282'b0, a};
      end
      return r;
   endfunction

   function automatic logic rdy(input int sel);
      case (sel)
         8:       return if8.in_ready;
         7:       return if7.in_ready;
         default: return if283.in_ready;
      endcase
   endfunction

   function automatic int qsize(input int sel);
      case (sel)
         8:       return q8.size();
         7:       return q7.size();
         default: return q283.size();
      endcase
   endfunction

   task automatic push(input int sel, input logic [564:0] exp);
      case (sel)
         8:       q8.push_back(exp);
         7:       q7.push_back(exp);
         default: q283.push_back(exp);
      endcase
   endtask

   task automatic drive(input int sel, input logic v, input logic [282:0] a, input logic [282:0] b);
      case (sel)
         8: begin
            if8.in_valid = v; if8.a = a[7:0]; if8.b = b[7:0];
         end
         7: begin
            if7.in_valid = v; if7.a = a[6:0]; if7.b = b[6:0];
         end
         default: begin
            if283.in_valid = v; if283.a = a; if283.b = b;
         end
      endcase
   endtask

   task automatic wait_rdy(input int sel);
      int c = 0;
      while (!rdy(sel) && c < 50) begin
         @(negedge clk);
         c++;
      end
      if (!rdy(sel)) timeout_fail("wait_in_ready");
   endtask

   task automatic wait_done(input int sel);
      int c = 0;
      while (qsize(sel) != 0 && c < 50) begin
         @(negedge clk);
         c++;
      end
      if (qsize(sel) != 0) timeout_fail("wait_product");
   endtask

   task automatic issue(input int sel, input logic [282:0] a, input logic [282:0] b, input logic [564:0] exp);
      wait_rdy(sel);
      drive(sel, 1'b1, a, b);
      push(sel, exp);
      @(posedge clk);
      #1;
      drive(sel, 1'b0, a, b);
      wait_done(sel);
   endtask

   // Scoreboards: compare y on the cycle the product is handed over
   always @(negedge clk) begin
      if (if8.out_valid && if8.out_ready) begin
         if (q8.size() == 0) timeout_fail("y8_unexpected");
         else check("y8", 565'(if8.y), q8.pop_front());
      end
      if (if7.out_valid && if7.out_ready) begin
         if (q7.size() == 0) timeout_fail("y7_unexpected");
         else check("y7", 565'(if7.y), q7.pop_front());
      end
      if (if283.out_valid && if283.out_ready) begin
         if (q283.size() == 0) timeout_fail("y283_unexpected");
         else check("y283", if283.y, q283.pop_front());
      end
   end

   initial begin
      vec_t         vec[8];
      logic [282:0] ones, top;
      logic [564:0] sq_ones, top_sq;
      logic [287:0] ra, rb;
      int           c;

      ones    = '1;
      top     = '0;
      top[282] = 1'b1;
      sq_ones = '0;
      for (int i = 0; i < 283; i++) sq_ones[2*i] = 1'b1;
      top_sq  = '0;
      top_sq[564] = 1'b1;

      vec[0] = '{8,   283'h03, 283'h03, 565'h0005};
      vec[1] = '{8,   283'hFF, 283'hFF, 565'h5555};
      vec[2] = '{8,   283'h80, 283'h80, 565'h4000};
      vec[3] = '{8,   283'h00, 283'hA5, 565'h0000};
      // (x^6+1) times seven ones: the x^6 terms cancel
      vec[4] = '{7,   283'h7F, 283'h41, 565'h1FBF};
      vec[5] = '{7,   283'h40, 283'h40, 565'h1000};
      vec[6] = '{283, ones,    ones,    sq_ones};
      vec[7] = '{283, top,     top,     top_sq};

      rst_n = 1'b0;
      drive(8, 1'b0, '0, '0);
      drive(7, 1'b0, '0, '0);
      drive(283, 1'b0, '0, '0);
      if8.out_ready = 1'b1;
      if7.out_ready = 1'b1;
      if283.out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready8",  565'(if8.in_ready), 565'(1));
      check("rst_out_valid8", 565'(if8.out_valid), 565'(0));
      check("rst_busy8",      565'(if8.busy), 565'(0));
      check("rst_y8",         565'(if8.y), 565'(0));
      check("rst_busy7",      565'(if7.busy), 565'(0));
      check("rst_y283",       if283.y, 565'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Latency: out_valid exactly three edges after the accepting edge
      wait_rdy(8);
      drive(8, 1'b1, 283'h03, 283'h03);
      push(8, 565'h5);
      @(posedge clk);
      #1;
      drive(8, 1'b0, 283'h1F, 283'h1F);
      check("lat_busy_e0",  565'(if8.busy), 565'(1));
      check("lat_ovld_e0",  565'(if8.out_valid), 565'(0));
      check("lat_inrdy_e0", 565'(if8.in_ready), 565'(0));
      for (int e = 1; e <= 2; e++) begin
         @(posedge clk);
         #1;
         check("lat_ovld_mid", 565'(if8.out_valid), 565'(0));
         check("lat_busy_mid", 565'(if8.busy), 565'(1));
      end
      @(posedge clk);
      #1;
      check("lat_ovld_e3", 565'(if8.out_valid), 565'(1));
      wait_done(8);

      // Table vectors
      for (int i = 0; i < 8; i++) begin
         issue(vec[i].sel, vec[i].a, vec[i].b, vec[i].exp);
      end

      // Backpressure: product held, operands ignored while DONE
      wait_rdy(8);
      if8.out_ready = 1'b0;
      drive(8, 1'b1, 283'hFF, 283'hFF);
      push(8, 565'h5555);
      @(posedge clk);
      #1;
      drive(8, 1'b0, '0, '0);
      c = 0;
      while (!if8.out_valid && c < 10) begin
         @(posedge clk);
         #1;
         c++;
      end
      check("bp_ovld", 565'(if8.out_valid), 565'(1));
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         drive(8, 1'($urandom_range(1)), 283'($urandom), 283'($urandom));
         @(posedge clk);
         #1;
         check("bp_y_hold",   565'(if8.y), 565'h5555);
         check("bp_in_ready", 565'(if8.in_ready), 565'(0));
         check("bp_ovld_hold", 565'(if8.out_valid), 565'(1));
      end
      // Operands offered in the releasing DONE cycle wait for IDLE
      drive(8, 1'b1, 283'h03, 283'h03);
      push(8, 565'h5);
      if8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_idle_busy",  565'(if8.busy), 565'(0));
      check("bp_idle_inrdy", 565'(if8.in_ready), 565'(1));
      check("bp_idle_ovld",  565'(if8.out_valid), 565'(0));
      @(posedge clk);
      #1;
      check("bp_next_accept", 565'(if8.busy), 565'(1));
      drive(8, 1'b0, '0, '0);
      wait_done(8);

      // Asynchronous reset while in M_HI
      wait_rdy(8);
      drive(8, 1'b1, 283'hC3, 283'h5A);
      @(posedge clk);
      #1;
      drive(8, 1'b0, '0, '0);
      @(posedge clk);
      #1;
      check("rst_mid_busy_before", 565'(if8.busy), 565'(1));
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_mid_ovld", 565'(if8.out_valid), 565'(0));
      check("rst_mid_y",    565'(if8.y), 565'(0));
      check("rst_mid_busy", 565'(if8.busy), 565'(0));
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      check("rst_mid_inrdy", 565'(if8.in_ready), 565'(1));
      @(negedge clk);
      issue(8, 283'h03, 283'h03, 565'h5);

      // Random N=283 operands against the reference model
      for (int i = 0; i < 1000; i++) begin
         for (int j = 0; j < 9; j++) begin
            ra[j*32 +: 32] = $urandom;
            rb[j*32 +: 32] = $urandom;
         end
         issue(283, ra[282:0], rb[282:0], clmul_ref(ra[282:0], rb[282:0]));
      end

      repeat (3) @(negedge clk);
      check("sb_drained", 565'(q8.size() + q7.size() + q283.size()), 565'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
